gbf_w_fetch_seq: RTL and testbench

Sequencer for the quad-port weight global buffer (GBF). On a start command it drives all four RAM ports with consecutive addresses, so the RAM delivers up to four weight words per cycle. Those words are registered into a single 4-lane output stream with valid/ready backpressure. It sits between the layer controller (which issues start/base/length) and the PE-array weight loader (which consumes the stream).

---
 rtl/gbf_w_fetch_seq.sv | 209 ++++++++++++++++++++
 tb/tb_gbf_w_fetch_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gbf_w_fetch_seq.sv
// rtl/gbf_w_fetch_seq.sv - quad-port weight GBF fetch sequencer; optional zero-clear mode via GBF_W_FETCH_CLEAR_EN
module gbf_w_fetch_seq #(
    parameter int WIDTH  = 32,
    parameter int HEIGHT = 48,
    parameter int AW     = $clog2(HEIGHT),
    parameter int LW     = $clog2(HEIGHT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AW-1:0]      base_addr,
    input  logic [LW-1:0]      num_words,
    output logic               busy,
    output logic               done,
    output logic [AW-1:0]      addr_a,
    output logic [AW-1:0]      addr_b,
    output logic [AW-1:0]      addr_c,
    output logic [AW-1:0]      addr_d,
    output logic               we_a,
    output logic               we_b,
    output logic               we_c,
    output logic               we_d,
    input  logic [WIDTH-1:0]   q_a,
    input  logic [WIDTH-1:0]   q_b,
    input  logic [WIDTH-1:0]   q_c,
    input  logic [WIDTH-1:0]   q_d,
    output logic [4*WIDTH-1:0] out_data,
    output logic [3:0]         out_mask,
    output logic               out_valid,
    input  logic               out_ready
`ifdef GBF_W_FETCH_CLEAR_EN
    ,
    input  logic               clr,
    output logic [4*WIDTH-1:0] wdata_zero
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [AW:0]   HEIGHT_A = HEIGHT[AW:0];
    localparam logic [LW-1:0] HEIGHT_L = HEIGHT[LW-1:0];
    localparam logic [LW-1:0] FOUR_L   = LW'(4);

    state_t              state;
    state_t              state_nxt;
    logic [AW-1:0]       ptr;
    logic [AW-1:0]       ptr_nxt;
    logic [LW-1:0]       rem;
    logic [LW-1:0]       rem_nxt;
    logic [LW-1:0]       rem_dec;
    logic [LW-1:0]       len_clamped;
    logic                clr_mode;
    logic                advance;
    logic                load;
    logic [3:0]          lane_on;
    logic [3:0]          we_vec;
    logic [4*WIDTH-1:0]  q_all;
    logic [4*WIDTH-1:0]  lane_data;
    logic [AW-1:0]       lane_addr [4];

    // Address step modulo HEIGHT; inc never exceeds 4 and ptr < HEIGHT, so one
    // conditional subtraction is enough.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input logic [2:0] inc);
        logic [AW:0] sum;
        sum = {1'b0, p} + {{(AW-2){1'b0}}, inc};
        if (sum >= HEIGHT_A) begin
            sum = sum - HEIGHT_A;
        end
        return sum[AW-1:0];
    endfunction

    assign q_all       = {q_d, q_c, q_b, q_a};
    assign len_clamped = (num_words > HEIGHT_L) ? HEIGHT_L : num_words;
    assign rem_dec     = (rem > FOUR_L) ? (rem - FOUR_L) : '0;

    // A fetch beat is taken when the output register is free; a clear never waits on the stream.
    assign advance = (state == FETCH) && (clr_mode || !out_valid || out_ready);
    assign load    = advance && !clr_mode;

    assign busy = (state == FETCH) || (state == DRAIN);
    assign done = (state == DONE);

`ifdef GBF_W_FETCH_CLEAR_EN
    assign wdata_zero = '0;

    // Command type is captured together with the start strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clr_mode <= 1'b0;
        end else if (state == IDLE && start) begin
            clr_mode <= clr;
        end
    end

    // Write enables follow the lane mask only while a clear command walks the range.
    always_comb begin
        we_vec = '0;
        if (state == FETCH && clr_mode) begin
            we_vec = lane_on;
        end
    end
`else
    assign clr_mode = 1'b0;
    assign we_vec   = '0;
`endif

    assign we_a = we_vec[0];
    assign we_b = we_vec[1];
    assign we_c = we_vec[2];
    assign we_d = we_vec[3];

    // Per-lane validity and read data, lanes past the remaining count forced to zero.
    always_comb begin
        lane_on   = '0;
        lane_data = '0;
        for (int k = 0; k < 4; k++) begin
            lane_on[k] = (rem > LW'(k));
            if (rem > LW'(k)) begin
                lane_data[k*WIDTH +: WIDTH] = q_all[k*WIDTH +: WIDTH];
            end
        end
    end

    // RAM addresses are only driven while fetching; ptr holds during a stall so they stay stable.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_addr[k] = '0;
            if (state == FETCH) begin
                lane_addr[k] = wrap_add(ptr, 3'(k));
            end
        end
    end

    assign addr_a = lane_addr[0];
    assign addr_b = lane_addr[1];
    assign addr_c = lane_addr[2];
    assign addr_d = lane_addr[3];

    // State, pointer and remaining-count registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            ptr   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            rem   <= rem_nxt;
        end
    end

    // Next-state logic. A zero-length command passes through DRAIN (empty) so
    // busy still shows for one cycle before done.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        case (state)
            IDLE: begin
                if (start) begin
                    ptr_nxt   = base_addr;
                    rem_nxt   = len_clamped;
                    state_nxt = (len_clamped != '0) ? FETCH : DRAIN;
                end
            end
            FETCH: begin
                if (advance) begin
                    ptr_nxt = wrap_add(ptr, 3'd4);
                    rem_nxt = rem_dec;
                    if (rem_dec == '0) begin
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid || out_ready) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output stream register: loads a new beat or empties on handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_mask  <= '0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= lane_data;
            out_mask  <= lane_on;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gbf_w_fetch_seq.sv
// tb/tb_gbf_w_fetch_seq.sv - self-checking bench for gbf_w_fetch_seq
module tb_gbf_w_fetch_seq;

    localparam int WIDTH  = 32;
    localparam int HEIGHT = 48;
    localparam int AW     = 6;
    localparam int LW     = 6;

    logic               clk;
    logic               rst;
    logic               start;
    logic [AW-1:0]      base_addr;
    logic [LW-1:0]      num_words;
    logic               busy;
    logic               done;
    logic [AW-1:0]      addr_a, addr_b, addr_c, addr_d;
    logic               we_a, we_b, we_c, we_d;
    logic [WIDTH-1:0]   q_a, q_b, q_c, q_d;
    logic [4*WIDTH-1:0] out_data;
    logic [3:0]         out_mask;
    logic               out_valid;
    logic               out_ready;

    logic [WIDTH-1:0]   mem [0:HEIGHT-1];

    typedef struct {
        logic [4*WIDTH-1:0] data;
        logic [3:0]         mask;
    } beat_t;

    typedef struct {
        int base;
        int num;
        int stall;
        int poke;
        int exp_lat;
        int exp_beats;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs [8];
    int    pass_cnt;
    int    total_cnt;
    int    beat_cnt;

    gbf_w_fetch_seq #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .num_words (num_words),
        .busy      (busy),
        .done      (done),
        .addr_a    (addr_a),
        .addr_b    (addr_b),
        .addr_c    (addr_c),
        .addr_d    (addr_d),
        .we_a      (we_a),
        .we_b      (we_b),
        .we_c      (we_c),
        .we_d      (we_d),
        .q_a       (q_a),
        .q_b       (q_b),
        .q_c       (q_c),
        .q_d       (q_d),
        .out_data  (out_data),
        .out_mask  (out_mask),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    assign q_a = mem[addr_a];
    assign q_b = mem[addr_b];
    assign q_c = mem[addr_c];
    assign q_d = mem[addr_d];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] mem_val(input int i);
        return 32'hC0DE_0000 | WIDTH'(i);
    endfunction

    task automatic check(input string name, input logic [4*WIDTH-1:0] act, input logic [4*WIDTH-1:0] req);
        total_cnt++;
        if (act === req) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference beats for a fetch of num words starting at base.
    task automatic push_beats(input int base, input int num);
        int    n;
        int    p;
        beat_t b;
        n = (num > HEIGHT) ? HEIGHT : num;
        p = base;
        while (n > 0) begin
            b.data = '0;
            b.mask = '0;
            for (int k = 0; k < 4; k++) begin
                if (k < n) begin
                    b.data[k*WIDTH +: WIDTH] = mem_val((p + k) % HEIGHT);
                    b.mask[k] = 1'b1;
                end
            end
            exp_q.push_back(b);
            p = (p + 4) % HEIGHT;
            n = n - ((n > 4) ? 4 : n);
        end
    endtask

    // Scoreboard: every accepted beat is popped and compared.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            beat_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {124'd0, out_mask}, 128'd0);
            end else begin
                check("beat_data", out_data, exp_q[0].data);
                check("beat_mask", {124'd0, out_mask}, {124'd0, exp_q[0].mask});
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic run_cmd(input vec_t v);
        int lat;
        int beats0;
        int clamp;
        clamp  = (v.num > HEIGHT) ? HEIGHT : v.num;
        beats0 = beat_cnt;
        push_beats(v.base, v.num);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = AW'(v.base);
        num_words = LW'(v.num);
        @(posedge clk); #1;
        start = (v.poke != 0);
        if (v.poke != 0) begin
            base_addr = AW'(30);
            num_words = LW'(4);
        end
        check("busy_t1", {127'd0, busy}, 128'd1);
        check("we_t1", {124'd0, we_a, we_b, we_c, we_d}, 128'd0);
        if (clamp > 0) begin
            check("addr_a_t1", {122'd0, addr_a}, 128'(v.base % HEIGHT));
            check("addr_b_t1", {122'd0, addr_b}, 128'((v.base + 1) % HEIGHT));
            check("addr_c_t1", {122'd0, addr_c}, 128'((v.base + 2) % HEIGHT));
            check("addr_d_t1", {122'd0, addr_d}, 128'((v.base + 3) % HEIGHT));
        end else begin
            check("addr_a_zero_len", {122'd0, addr_a}, 128'd0);
        end
        lat = 0;
        for (int k = 1; k < 200; k++) begin
            if (k == 3) begin
                start = 1'b0;
            end
            if (k == 2) begin
                check("valid_t2", {127'd0, out_valid}, 128'(clamp != 0));
                if (v.stall > 0) begin
                    out_ready = 1'b0;
                end
            end
            if (v.stall > 0 && k >= 2 && k < 2 + v.stall) begin
                check("stall_valid", {127'd0, out_valid}, 128'd1);
                check("stall_data", out_data, exp_q[0].data);
                check("stall_addr", {122'd0, addr_a}, 128'((v.base + 4) % HEIGHT));
            end
            if (v.stall > 0 && k == 2 + v.stall) begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            if (done) begin
                lat = k;
                check("busy_at_done", {127'd0, busy}, 128'd0);
                break;
            end
            @(posedge clk); #1;
        end
        start     = 1'b0;
        out_ready = 1'b1;
        check("done_latency", 128'(lat), 128'(v.exp_lat));
        check("beat_count", 128'(beat_cnt - beats0), 128'(v.exp_beats));
        check("queue_empty", 128'(exp_q.size()), 128'd0);
        exp_q.delete();
    endtask

    initial begin
        vec_t fresh;
        pass_cnt  = 0;
        total_cnt = 0;
        beat_cnt  = 0;
        for (int i = 0; i < HEIGHT; i++) begin
            mem[i] = mem_val(i);
        end

        //         base num stall poke lat beats
        vecs[0] = '{0,   8,  0,    0,   4,  2};
        vecs[1] = '{46,  6,  0,    0,   4,  2};
        vecs[2] = '{0,   8,  3,    0,   7,  2};
        vecs[3] = '{0,   0,  0,    0,   2,  0};
        vecs[4] = '{3,   60, 0,    0,   14, 12};
        vecs[5] = '{5,   1,  0,    0,   3,  1};
        vecs[6] = '{47,  4,  0,    0,   3,  1};
        vecs[7] = '{0,   8,  0,    1,   4,  2};

        rst       = 1'b1;
        start     = 1'b0;
        base_addr = '0;
        num_words = '0;
        out_ready = 1'b1;
        #3;
        check("rst_busy", {127'd0, busy}, 128'd0);
        check("rst_done", {127'd0, done}, 128'd0);
        check("rst_valid", {127'd0, out_valid}, 128'd0);
        check("rst_mask", {124'd0, out_mask}, 128'd0);
        check("rst_data", out_data, 128'd0);
        check("rst_addr", {104'd0, addr_a, addr_b, addr_c, addr_d}, 128'd0);
        check("rst_we", {124'd0, we_a, we_b, we_c, we_d}, 128'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i]);
        end

        // After the ignored start pulses, nothing further may happen.
        repeat (3) @(posedge clk);
        #1;
        check("poke_idle_busy", {127'd0, busy}, 128'd0);
        check("poke_idle_valid", {127'd0, out_valid}, 128'd0);

        // Mid-command asynchronous reset between beat 1 and beat 2.
        push_beats(0, 8);
        @(posedge clk); #1;
        start     = 1'b1;
        base_addr = '0;
        num_words = LW'(8);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_valid_pre_rst", {127'd0, out_valid}, 128'd1);
        rst = 1'b1;
        #1;
        check("mid_rst_valid", {127'd0, out_valid}, 128'd0);
        check("mid_rst_busy", {127'd0, busy}, 128'd0);
        check("mid_rst_done", {127'd0, done}, 128'd0);
        check("mid_rst_data", out_data, 128'd0);
        check("mid_rst_mask", {124'd0, out_mask}, 128'd0);
        check("mid_rst_addr", {104'd0, addr_a, addr_b, addr_c, addr_d}, 128'd0);
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;

        fresh = '{12, 5, 0, 0, 4, 2};
        run_cmd(fresh);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
